// File: rtl/ldpc5_syndrome_check.sv
// Receive-side parity check for the encoder5 quasi-cyclic LDPC code: regenerates
// the 360 parity bits from the received information bits and counts mismatches.
module ldpc5_syndrome_check #(
    parameter int GROUP    = 360,
    parameter int N_GROUPS = 12,
    parameter int ERR_W    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             din_valid,
    input  logic             din,
    output logic             ready,
    output logic             done,
    output logic             check_ok,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       rom_addr,
    input  logic [GROUP-1:0] rom_data
);

    localparam int              BIT_W    = $clog2(GROUP);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(GROUP - 1);
    localparam logic [3:0]       LAST_GRP = 4'(N_GROUPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INFO,
        S_PAR,
        S_DONE
    } state_t;

    state_t           state;
    logic [GROUP-1:0] acc;
    logic [GROUP-1:0] rot;
    logic [BIT_W-1:0] bit_idx;
    logic [3:0]       grp_idx;
    logic             load_cnt;

    logic take;
    logic par_mismatch;

    assign take = din_valid & ready;
    // Parity bits arrive MSB of the accumulator first.
    assign par_mismatch = din ^ acc[LAST_BIT - bit_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ready    <= 1'b0;
            done     <= 1'b0;
            check_ok <= 1'b0;
            err_cnt  <= '0;
            rom_addr <= '0;
            acc      <= '0;
            rot      <= '0;
            bit_idx  <= '0;
            grp_idx  <= '0;
            load_cnt <= 1'b0;
        end else begin
            // NOTE: default-low assignment makes done a single-cycle pulse without
            // every branch having to clear it; later assignments in this block win.
            done <= 1'b0;

            if (sof) begin
                // sof outranks everything, so a bit accepted in the same cycle is dropped.
                state    <= S_LOAD;
                ready    <= 1'b0;
                check_ok <= 1'b0;
                err_cnt  <= '0;
                rom_addr <= '0;
                acc      <= '0;
                bit_idx  <= '0;
                grp_idx  <= '0;
                load_cnt <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        ready <= 1'b0;
                    end

                    S_LOAD: begin
                        // Wait one cycle for the address register, one for the ROM read.
                        if (load_cnt) begin
                            rot   <= rom_data;
                            state <= S_INFO;
                            ready <= 1'b1;
                        end else begin
                            load_cnt <= 1'b1;
                        end
                    end

                    S_INFO: begin
                        if (take) begin
                            if (din)
                                acc <= acc ^ rot;

                            if (bit_idx == '0 && grp_idx != LAST_GRP)
                                rom_addr <= grp_idx + 4'd1;

                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                if (grp_idx == LAST_GRP) begin
                                    state <= S_PAR;
                                end else begin
                                    grp_idx <= grp_idx + 4'd1;
                                    rot     <= rom_data;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                rot     <= {rot[0], rot[GROUP-1:1]};
                            end
                        end
                    end

                    S_PAR: begin
                        if (take) begin
                            if (par_mismatch)
                                err_cnt <= err_cnt + 1'b1;

                            if (bit_idx == LAST_BIT) begin
                                bit_idx  <= '0;
                                state    <= S_DONE;
                                ready    <= 1'b0;
                                done     <= 1'b1;
                                check_ok <= (err_cnt == '0) && !par_mismatch;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end

                    S_DONE: begin
                        state    <= S_IDLE;
                        rom_addr <= '0;
                    end

                    default: begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ldpc5_syndrome_check.sv
// Randomized bench for ldpc5_syndrome_check: random generator ROM, frames encoded by
// a modular-arithmetic parity model, random parity corruption and din_valid gaps.
module tb_ldpc5_syndrome_check;

    localparam int GROUP    = 360;
    localparam int N_GROUPS = 12;
    localparam int ERR_W    = 9;
    localparam int K        = GROUP * N_GROUPS;
    localparam int N        = K + GROUP;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sof;
    logic             din_valid;
    logic             din;
    logic             ready;
    logic             done;
    logic             check_ok;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       rom_addr;
    logic [GROUP-1:0] rom_data;

    ldpc5_syndrome_check #(
        .GROUP   (GROUP),
        .N_GROUPS(N_GROUPS),
        .ERR_W   (ERR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sof      (sof),
        .din_valid(din_valid),
        .din      (din),
        .ready    (ready),
        .done     (done),
        .check_ok (check_ok),
        .err_cnt  (err_cnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // Generator ROM with one-cycle registered read.
    logic [GROUP-1:0] rom [N_GROUPS];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int checks     = 0;
    int errors     = 0;
    int done_seen  = 0;
    int addr_bad   = 0;
    int ready_drops = 0;

    logic [K-1:0]     info_bits;
    logic [GROUP-1:0] exp_par;   // exp_par[j] = parity bit j in arrival order
    logic [GROUP-1:0] par_bits;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (rst_n && rom_addr > 4'(N_GROUPS - 1)) addr_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Parity = XOR over set info bits i of ROM row i/GROUP rotated right by i%GROUP.
    task automatic prepare_parity();
        logic [GROUP-1:0] a;
        int g;
        int b;
        a = '0;
        for (int i = 0; i < K; i++) begin
            if (info_bits[i]) begin
                g = i / GROUP;
                b = i % GROUP;
                for (int k = 0; k < GROUP; k++)
                    a[k] = a[k] ^ rom[g][(k + b) % GROUP];
            end
        end
        for (int j = 0; j < GROUP; j++)
            exp_par[j] = a[GROUP-1-j];
    endtask

    task automatic randomize_info();
        for (int i = 0; i < K; i++) info_bits[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic push_bit(input logic b, input int gap_pct, input bit track, output bit ok);
        int n;
        ok = 1'b1;
        if (gap_pct > 0) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                din_valid = 1'b0;
                din = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (track && !ready) ready_drops++;
            end
        end
        n = 0;
        while (!ready && n < 8) begin
            din_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            check("ready_wait", ready, 1);
            ok = 1'b0;
        end else begin
            din_valid = 1'b1;
            din = b;
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic start_frame(input logic dv_with_sof);
        sof = 1'b1;
        din_valid = dv_with_sof;
        din = 1'b1;
        @(posedge clk); #1;
        sof = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic send_bits(input int count, input int gap_pct, input bit track);
        bit ok;
        logic b;
        for (int n = 0; n < count; n++) begin
            b = (n < K) ? info_bits[n] : par_bits[n-K];
            push_bit(b, gap_pct, track && (n > 0), ok);
            if (!ok) break;
        end
    endtask

    task automatic run_full(input string tag, input int gap_pct, input int exp_err,
                            input logic dv_with_sof);
        int d0;
        ready_drops = 0;
        start_frame(dv_with_sof);
        d0 = done_seen;
        send_bits(N, gap_pct, 1'b1);
        check({tag, ":done"}, done, 1);
        check({tag, ":err_cnt"}, err_cnt, exp_err);
        check({tag, ":check_ok"}, check_ok, (exp_err == 0) ? 1 : 0);
        check({tag, ":ready_held"}, ready_drops, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ":done_count"}, done_seen - d0, 1);
        check({tag, ":hold_ok"}, check_ok, (exp_err == 0) ? 1 : 0);
        check({tag, ":idle_addr"}, rom_addr, 0);
    endtask

    initial begin
        int d0;
        int exp_w;
        logic [GROUP-1:0] flips;

        rst_n = 1'b0;
        sof = 1'b0;
        din_valid = 1'b0;
        din = 1'b0;
        for (int r = 0; r < N_GROUPS; r++)
            for (int k = 0; k < GROUP; k++)
                rom[r][k] = 1'($urandom_range(0, 1));

        repeat (3) @(posedge clk);
        #1;
        check("rst:ready", ready, 0);
        check("rst:done", done, 0);
        check("rst:check_ok", check_ok, 0);
        check("rst:err_cnt", err_cnt, 0);
        check("rst:rom_addr", rom_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray din_valid while idle must be ignored.
        din_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("idle:ready", ready, 0);
        check("idle:no_done", done_seen, 0);

        info_bits = '0;
        prepare_parity();
        par_bits = exp_par;
        run_full("zero", 0, 0, 1'b0);

        randomize_info();
        prepare_parity();
        par_bits = exp_par;
        run_full("enc", 0, 0, 1'b0);

        flips = '0;
        flips[5] = 1'b1;
        par_bits = exp_par ^ flips;
        run_full("flip5", 0, 1, 1'b0);

        par_bits = ~exp_par;
        run_full("flip_all", 0, GROUP, 1'b0);

        info_bits = '0;
        info_bits[0] = 1'b1;
        par_bits = '0;
        exp_w = $countones(rom[0]);
        run_full("info0", 0, exp_w, 1'b0);

        randomize_info();
        prepare_parity();
        par_bits = exp_par;
        run_full("gapped", 30, 0, 1'b0);

        for (int j = 0; j < GROUP; j++) flips[j] = ($urandom_range(0, 99) < 10);
        par_bits = exp_par ^ flips;
        run_full("rand_err", 15, $countones(flips), 1'b1);

        // Abort at info bit 2000, restart with sof coincident with din_valid.
        par_bits = exp_par;
        d0 = done_seen;
        start_frame(1'b0);
        send_bits(2000, 0, 1'b0);
        run_full("abort", 0, 0, 1'b1);
        check("abort:single_done", done_seen - d0, 1);

        // Reset in the middle of the parity section.
        par_bits = ~exp_par;
        d0 = done_seen;
        start_frame(1'b0);
        send_bits(K + 100, 0, 1'b0);
        check("par:err_before_rst", err_cnt, 100);
        rst_n = 1'b0;
        #1;
        check("midrst:ready", ready, 0);
        check("midrst:err_cnt", err_cnt, 0);
        check("midrst:rom_addr", rom_addr, 0);
        check("midrst:check_ok", check_ok, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        din_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("midrst:stay_idle", ready, 0);
        check("midrst:no_done", done_seen - d0, 0);
        par_bits = exp_par;
        run_full("after_rst", 0, 0, 1'b0);

        check("rom_addr_range", addr_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ldpc5_syndrome_check.md
Name: ldpc5_syndrome_check

Overview:
- Receive-side companion to the encoder5 parity generator. Takes a hard-decision received frame as a serial bit stream: 4320 information bits followed by 360 parity bits.
- Regenerates the parity from the information bits using the same quasi-cyclic generator ROM and the same rotate/accumulate rule as the encoder.
- Compares each received parity bit against the regenerated one and reports the mismatch count and a pass flag per frame.
- Sits after the demapper/hard slicer; its result gates the downstream payload-valid path.

Parameters:
- GROUP, 360, bits per circulant group; also the parity length and ROM row width.
- N_GROUPS, 12, number of information groups (K = N_GROUPS*GROUP = 4320).
- ERR_W, 9, width of the mismatch counter; must hold GROUP.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start-of-frame pulse; aborts any frame in progress.
- din_valid  in  1  qualifies din; sampled only while ready=1.
- din  in  1  received hard bit.
- ready  out  1  block accepts bits this cycle.
- done  out  1  one-cycle pulse when the frame check completes.
- check_ok  out  1  1 = all 360 parity bits matched; valid from done until next sof.
- err_cnt  out  ERR_W  parity mismatch count of the current/last frame.
- rom_addr  out  4  generator ROM row address (to G_rom5 addra).
- rom_data  in  GROUP  generator ROM row (G_rom5 douta); 1-cycle registered read latency.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=0, done=0, check_ok=0, err_cnt=0, rom_addr=0, accumulator=0, rotate reg=0, counters=0.
- States: IDLE, LOAD, INFO, PAR, DONE.
- IDLE: ready=0. sof -> LOAD.
- LOAD:
  - rom_addr=0; acc, err_cnt and check_ok cleared on sof.
  - 2-cycle wait (address register plus ROM latency), then rot <= rom_data (row 0) and go to INFO.
- INFO:
  - ready=1. Per accepted bit (din_valid=1): if din=1, acc <= acc ^ rot, using rot before rotation.
  - rot <= {rot[0], rot[GROUP-1:1]} (rotate right by 1).
  - bit_idx and grp_idx advance.
- Prefetch: on the first accepted bit of group g (g < N_GROUPS-1), rom_addr <= g+1. The address is held constant until the next group starts, so rom_data is stable long before the group ends.
- Group boundary: on the accepted bit with bit_idx = GROUP-1 and g < N_GROUPS-1:
  - the rotate register loads rom_data (row g+1) instead of rotating;
  - the XOR in that cycle still uses the old rot.
- Last info bit: after bit 4319 is accepted, go to PAR. rot is no longer used.
- PAR:
  - ready=1. Parity bit j (j = 0..GROUP-1, in arrival order) is compared with acc[GROUP-1-j]; a mismatch increments err_cnt.
  - acc is not modified in PAR.
  - After j = GROUP-1 is accepted, go to DONE.
- DONE (one cycle):
  - done=1 and check_ok=(err_cnt==0); err_cnt already includes the last parity bit.
  - Then IDLE. check_ok and err_cnt are held until the next sof.
- din_valid gaps: any number of idle cycles between bits. State and counters freeze; no ROM reload and no rotation occur.
- sof in any state, including coincident with din_valid: the din of that cycle is discarded, the frame restarts in LOAD, and no done is produced for the aborted frame.
- din_valid while ready=0: ignored.
- Reset mid-frame: immediate return to reset values; no done.
- rom_addr never exceeds N_GROUPS-1. Address 0 is used in IDLE and LOAD.
- Throughput: 1 bit/clk; frame overhead 3 cycles (2 LOAD + 1 DONE).

Test Plan:
- All-zero frame (4680 zeros, din_valid continuous) -> done one cycle after bit 4679 accepted; check_ok=1, err_cnt=0.
- Random 4320 info bits encoded by encoder5, then its 360 parity bits (out_addr 359..0) streamed in -> check_ok=1, err_cnt=0.
- Same frame with parity bit j=5 inverted -> check_ok=0, err_cnt=1; with all 360 parity bits inverted -> err_cnt=360.
- All-zero frame except info bit 0 = 1 -> err_cnt equals the Hamming weight of ROM row 0.
- Valid frame with random din_valid gaps (about 30% idle) -> identical result to the gapless run; ready stays 1 through INFO and PAR.
- sof asserted at info bit 2000, followed by a full valid frame -> exactly one done, check_ok=1. rst_n pulsed low mid-PAR -> all outputs 0, no done until the next sof and a complete frame.
